// File: rtl/cpu_pkg.sv
// cpu_pkg: shared writeback entry type and default sizing for the ALU writeback buffer.
package cpu_pkg;
    localparam int DEPTH_DEF  = 4;
    localparam int DATA_W_DEF = 32;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic                  zero;
        logic [4:0]            rd;
        logic                  we;
    } entry_t;
endpackage

// File: rtl/wb_fifo_mem.sv
// wb_fifo_mem: unreset entry storage with one write port, one read port and a full view for forwarding.
module wb_fifo_mem
    import cpu_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  entry_t        wdata,
    input  logic [AW-1:0] raddr,
    output entry_t        rdata,
    output entry_t        entries [DEPTH]
);
    entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata   = mem_q[raddr];
    assign entries = mem_q;
endmodule

// File: rtl/alu_writeback_buffer.sv
// alu_writeback_buffer: FIFO of ALU results awaiting register writeback, with youngest-match forwarding.
module alu_writeback_buffer
    import cpu_pkg::*;
#(
    parameter  int DEPTH  = DEPTH_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    input  logic [4:0]        rd_addr,
    input  logic              reg_write,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_zero,
    output logic [4:0]        wb_rd,
    output logic              wb_we,
    input  logic [4:0]        src_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic              zero_flag,
    output logic [CW-1:0]     count
);
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          zero_q, zero_d;
    logic          push, pop;
    entry_t        wr_entry, head;
    entry_t        entries [DEPTH];

    assign out_valid = count_q != '0;
    assign in_ready  = (count_q < CW'(DEPTH)) | out_ready;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign wr_entry  = '{data: alu_out, zero: alu_zero, rd: rd_addr, we: reg_write};

    wb_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk    (clk),
        .we     (push & ~flush),
        .waddr  (wr_ptr_q),
        .wdata  (wr_entry),
        .raddr  (rd_ptr_q),
        .rdata  (head),
        .entries(entries)
    );

    always_comb begin
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
        count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
        zero_d   = (pop & ~flush) ? head.zero : zero_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            zero_q   <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            zero_q   <= zero_d;
        end
    end

    // Storage is unreset, so every view of it is gated by occupancy.
    assign wb_data   = out_valid ? head.data : '0;
    assign wb_zero   = out_valid & head.zero;
    assign wb_rd     = out_valid ? head.rd : '0;
    assign wb_we     = out_valid & head.we;
    assign zero_flag = zero_q;
    assign count     = count_q;

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        logic [AW-1:0] idx;
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + AW'(i);
            if (CW'(i) < count_q && entries[idx].we && entries[idx].rd == src_addr && src_addr != 5'd0) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[idx].data;
            end
        end
    end
endmodule

// File: tb/tb_alu_writeback_buffer.sv
// tb_alu_writeback_buffer: scoreboard bench with a queue-based reference model of the writeback buffer.
module tb_alu_writeback_buffer;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;

    typedef struct {
        logic [31:0] data;
        logic        zero;
        logic [4:0]  rd;
        logic        we;
    } tb_ent_t;

    logic              clk = 0, rst_n = 0;
    logic              in_valid = 0, in_ready, alu_zero = 0, reg_write = 0, flush = 0;
    logic              out_valid, out_ready = 0, wb_zero, wb_we, fwd_hit, zero_flag;
    logic [DATA_W-1:0] alu_out = '0, wb_data, fwd_data;
    logic [4:0]        rd_addr = '0, wb_rd, src_addr = '0;
    logic [2:0]        count;

    tb_ent_t exp_q[$];
    logic    exp_zero = 0;
    int      checks = 0, errors = 0;

    alu_writeback_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .alu_zero(alu_zero), .rd_addr(rd_addr), .reg_write(reg_write),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .wb_data(wb_data), .wb_zero(wb_zero), .wb_rd(wb_rd), .wb_we(wb_we),
        .src_addr(src_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .zero_flag(zero_flag), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, a, e);
        end
    endtask

    // Monitor: checks the cycle's outputs mid-cycle, then retires the head from the model.
    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            logic        hit;
            logic [31:0] fd;
            hit = 0;
            fd  = 0;
            foreach (exp_q[k])
                if (exp_q[k].we && exp_q[k].rd == src_addr && src_addr != 0) begin
                    hit = 1;
                    fd  = exp_q[k].data;
                end
            chk("count", 64'(count), 64'(exp_q.size()));
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            chk("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH || out_ready));
            chk("zero_flag", 64'(zero_flag), 64'(exp_zero));
            chk("fwd_hit", 64'(fwd_hit), 64'(hit));
            chk("fwd_data", 64'(fwd_data), 64'(fd));
            if (exp_q.size() != 0) begin
                chk("wb_data", 64'(wb_data), 64'(exp_q[0].data));
                chk("wb_zero", 64'(wb_zero), 64'(exp_q[0].zero));
                chk("wb_rd", 64'(wb_rd), 64'(exp_q[0].rd));
                chk("wb_we", 64'(wb_we), 64'(exp_q[0].we));
                if (out_ready && !flush) begin
                    exp_zero = exp_q[0].zero;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic z, input logic [4:0] rd,
                         input logic we, input logic ordy, input logic fl, input logic [4:0] src);
        logic acc;
        @(negedge clk);
        in_valid = v; alu_out = d; alu_zero = z; rd_addr = rd; reg_write = we;
        out_ready = ordy; flush = fl; src_addr = src;
        acc = v && !fl && (exp_q.size() < DEPTH || ordy);
        #3;
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back('{data: d, zero: z, rd: rd, we: we});
    endtask

    task automatic idle(input logic ordy, input logic [4:0] src);
        drive(0, 32'h0, 0, 5'd0, 0, ordy, 0, src);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_count"}, 64'(count), 0);
        chk({tag, "_out_valid"}, 64'(out_valid), 0);
        chk({tag, "_in_ready"}, 64'(in_ready), 1);
        chk({tag, "_zero_flag"}, 64'(zero_flag), 0);
        chk({tag, "_fwd_hit"}, 64'(fwd_hit), 0);
        chk({tag, "_wb"}, 64'({wb_data, wb_zero, wb_rd, wb_we}), 0);
    endtask

    initial begin
        #1;
        reset_checks("por");
        repeat (2) @(negedge clk);
        #1 rst_n = 1;
        // First push visible next cycle with forwarding on rd 3.
        drive(1, 32'h5, 0, 5'd3, 1, 0, 0, 5'd3);
        idle(0, 5'd3);
        // Fill, stall a fifth result, then push and pop together at full.
        for (int i = 0; i < 3; i++) drive(1, 32'h100 + i, 0, 5'd8 + 5'(i), 1, 0, 0, 5'd3);
        drive(1, 32'hABC, 0, 5'd12, 1, 0, 0, 5'd9);
        drive(1, 32'hABC, 0, 5'd12, 1, 1, 0, 5'd12);
        repeat (5) idle(1, 5'd12);
        // Youngest match wins and survives the older entry's retirement.
        drive(1, 32'h11, 0, 5'd7, 1, 0, 0, 5'd7);
        drive(1, 32'h22, 0, 5'd7, 1, 0, 0, 5'd7);
        idle(1, 5'd7);
        idle(1, 5'd7);
        idle(0, 5'd7);
        // Zero flag tracks the retired entry.
        drive(1, 32'h0, 1, 5'd4, 1, 0, 0, 5'd0);
        idle(1, 5'd0);
        idle(0, 5'd0);
        drive(1, 32'h9, 0, 5'd4, 1, 0, 0, 5'd0);
        idle(1, 5'd0);
        idle(0, 5'd0);
        // Flush at count 3 overrides a concurrent push and pop.
        for (int i = 0; i < 3; i++) drive(1, 32'h200 + i, 0, 5'd5, 1, 0, 0, 5'd5);
        drive(1, 32'h300, 0, 5'd5, 1, 1, 1, 5'd5);
        idle(0, 5'd5);
        // Asynchronous reset between edges with two entries buffered.
        drive(1, 32'h44, 0, 5'd6, 1, 0, 0, 5'd6);
        drive(1, 32'h55, 1, 5'd6, 1, 0, 0, 5'd6);
        @(negedge clk);
        in_valid = 0; out_ready = 0; flush = 0;
        #1 rst_n = 0;
        #1 reset_checks("async");
        exp_q.delete();
        exp_zero = 0;
        @(negedge clk);
        #1 rst_n = 1;
        drive(1, 32'h77, 0, 5'd0, 1, 0, 0, 5'd0);
        idle(0, 5'd0);
        idle(1, 5'd0);
        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0,
                  5'($urandom_range(0, 7)));
        repeat (6) idle(1, 5'd0);
        @(negedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
